// File: rtl/snake_tile_painter.sv
// Draw-command executor: queues {op, coords, color} commands and expands them into tile writes.
// Optional SNAKE_PAINTER_WR_READY_EN adds a wr_rdy handshake that stalls the write port.
module snake_tile_painter #(
   parameter int                       H_LOGIC_WIDTH  = 5,
   parameter int                       V_LOGIC_WIDTH  = 5,
   parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX    = 5'd31,
   parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX    = 5'd23,
   parameter int                       COLOR_ID_WIDTH = 8,
   parameter int                       FIFO_DEPTH     = 4,
   localparam int CMD_WIDTH  = 4 + 2*(H_LOGIC_WIDTH+V_LOGIC_WIDTH) + COLOR_ID_WIDTH,
   localparam int ADDR_WIDTH = V_LOGIC_WIDTH + H_LOGIC_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CMD_WIDTH-1:0]      cmd,
   input  logic                      cmd_vld,
`ifdef SNAKE_PAINTER_WR_READY_EN
   input  logic                      wr_rdy,
`endif
   output logic                      wr_en,
   output logic [ADDR_WIDTH-1:0]     wr_addr,
   output logic [COLOR_ID_WIDTH-1:0] wr_data,
   output logic                      busy,
   output logic                      overflow,
   output logic [7:0]                drop_cnt
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam int X0_MSB = CMD_WIDTH - 5;
   localparam int Y0_MSB = X0_MSB - H_LOGIC_WIDTH;
   localparam int X1_MSB = Y0_MSB - V_LOGIC_WIDTH;
   localparam int Y1_MSB = X1_MSB - H_LOGIC_WIDTH;

   typedef enum logic [1:0] {IDLE, POINT, FILL} state_t;

   state_t state, state_nxt;

   logic [CMD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 push, pop, issue, stall;

   logic [CMD_WIDTH-1:0]      head;
   logic [3:0]                op;
   logic                      is_fill;
   logic [H_LOGIC_WIDTH-1:0]  d_x0, d_x1, d_xa, d_xm, d_xb;
   logic [V_LOGIC_WIDTH-1:0]  d_y0, d_y1, d_ya, d_ym, d_yb;
   logic [COLOR_ID_WIDTH-1:0] d_color;
   logic                      d_skip;

   logic [H_LOGIC_WIDTH-1:0]  cur_x, xa_r, xb_r;
   logic [V_LOGIC_WIDTH-1:0]  cur_y, yb_r;
   logic [COLOR_ID_WIDTH-1:0] color_r;
   logic                      skip_r;

`ifdef SNAKE_PAINTER_WR_READY_EN
   assign stall = wr_en & ~wr_rdy;
`else
   assign stall = 1'b0;
`endif

   // A point is decoded as a one-tile fill, so both share the bounds logic.
   assign head    = fifo_mem[rd_ptr];
   assign op      = head[CMD_WIDTH-1 -: 4];
   assign is_fill = (op == 4'h1);
   assign d_x0    = head[X0_MSB -: H_LOGIC_WIDTH];
   assign d_y0    = head[Y0_MSB -: V_LOGIC_WIDTH];
   assign d_x1    = is_fill ? head[X1_MSB -: H_LOGIC_WIDTH] : d_x0;
   assign d_y1    = is_fill ? head[Y1_MSB -: V_LOGIC_WIDTH] : d_y0;
   assign d_color = is_fill ? head[COLOR_ID_WIDTH-1:0] : head[X1_MSB -: COLOR_ID_WIDTH];

   assign d_xa   = (d_x1 < d_x0) ? d_x1 : d_x0;
   assign d_xm   = (d_x1 < d_x0) ? d_x0 : d_x1;
   assign d_ya   = (d_y1 < d_y0) ? d_y1 : d_y0;
   assign d_ym   = (d_y1 < d_y0) ? d_y0 : d_y1;
   assign d_xb   = ({1'b0, d_xm} > {1'b0, H_LOGIC_MAX}) ? H_LOGIC_MAX : d_xm;
   assign d_yb   = ({1'b0, d_ym} > {1'b0, V_LOGIC_MAX}) ? V_LOGIC_MAX : d_ym;
   assign d_skip = ({1'b0, d_xa} > {1'b0, H_LOGIC_MAX}) || ({1'b0, d_ya} > {1'b0, V_LOGIC_MAX});

   assign push = cmd_vld && ((count < FULL_CNT) || pop);
   assign busy = (state != IDLE) || (count != '0) || wr_en;

   always_comb begin
      // NOTE: every always_comb output is given a default first so no latch is inferred.
      state_nxt = state;
      pop       = 1'b0;
      issue     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!stall && count != '0) begin
               pop = 1'b1;
               if (op == 4'h0)   state_nxt = POINT;
               else if (is_fill) state_nxt = FILL;
            end
         end
         POINT: begin
            if (!stall) begin
               issue     = !skip_r;
               state_nxt = IDLE;
            end
         end
         FILL: begin
            if (!stall) begin
               issue = !skip_r;
               if (skip_r || (cur_x == xb_r && cur_y == yb_r)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cmd_vld && !push) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
         end
         if (!stall) begin
            wr_en <= issue;
            if (issue) begin
               wr_addr <= {cur_y, cur_x};
               wr_data <= color_r;
            end
         end
      end
   end

   // NOTE: storage and decoded fields are not reset; they are only read after a push or pop.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd;
      if (pop) begin
         cur_x   <= d_xa;
         cur_y   <= d_ya;
         xa_r    <= d_xa;
         xb_r    <= d_xb;
         yb_r    <= d_yb;
         color_r <= d_color;
         skip_r  <= d_skip;
      end else if (issue) begin
         if (cur_x == xb_r) begin
            cur_x <= xa_r;
            cur_y <= cur_y + 1'b1;
         end else begin
            cur_x <= cur_x + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_snake_tile_painter.sv
// Scoreboard bench for snake_tile_painter: stimulus queues expected writes, a monitor checks them.
module tb_snake_tile_painter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmd = '0;
   logic        cmd_vld = 1'b0;
`ifdef SNAKE_PAINTER_WR_READY_EN
   logic        wr_rdy = 1'b1;
`endif
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        overflow;
   logic [7:0]  drop_cnt;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
      int         cyc;   // -1: cycle not checked
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   n_writes = 0;

   snake_tile_painter dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd),
      .cmd_vld  (cmd_vld),
`ifdef SNAKE_PAINTER_WR_READY_EN
      .wr_rdy   (wr_rdy),
`endif
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] point_cmd(input logic [4:0] x, input logic [4:0] y,
                                             input logic [7:0] c);
      return {4'h0, x, y, c, 10'b0};
   endfunction

   function automatic logic [31:0] fill_cmd(input logic [4:0] x0, input logic [4:0] y0,
                                            input logic [4:0] x1, input logic [4:0] y1,
                                            input logic [7:0] c);
      return {4'h1, x0, y0, x1, y1, c};
   endfunction

   task automatic push_exp(input logic [9:0] a, input logic [7:0] d, input int c);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Called #1 after a clock edge; cmd is sampled at the next edge, whose number is returned.
   task automatic send(input logic [31:0] c, output int n);
      cmd     = c;
      cmd_vld = 1'b1;
      n       = cyc + 1;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      cmd     = '0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b0 && wr_en === 1'b0) break;
      end
      check({tag, "_idle"}, 32'(busy | wr_en), 32'd0);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               check("spurious_wr_en", 32'(wr_en), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(wr_addr), 32'(e.addr));
               check("wr_data", 32'(wr_data), 32'(e.data));
               if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int n, m, k, base;

      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en",    32'(wr_en),    32'd0);
      check("rst_wr_addr",  32'(wr_addr),  32'd0);
      check("rst_wr_data",  32'(wr_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b0;

      // Single point at (3,5): one write at {5,3} = 163, visible two cycles after the push edge.
      send(point_cmd(5'd3, 5'd5, 8'h0f), n);
      push_exp(10'd163, 8'h0f, n + 2);
      @(posedge clk);
      #1;
      check("t1_busy_after_pop", 32'(busy), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("t1_busy_after_write", 32'(busy), 32'd0);
      check("t1_pending", 32'(exp_q.size()), 32'd0);

      // Full-screen clear: 768 back-to-back writes, ascending addresses.
      send(fill_cmd(5'd0, 5'd0, 5'd31, 5'd23, 8'hff), n);
      for (int i = 0; i < 768; i++) push_exp(10'(i), 8'hff, n + 2 + i);
      repeat (100) @(posedge clk);
      #1;
      check("t2_busy_mid", 32'(busy), 32'd1);
      wait_idle(1000, "t2");

      // Burst of three points on consecutive cycles: writes two cycles apart.
      send(point_cmd(5'd2, 5'd4, 8'h0f), n);
      push_exp(10'd130, 8'h0f, n + 2);
      send(point_cmd(5'd1, 5'd4, 8'hff), m);
      push_exp(10'd129, 8'hff, n + 4);
      send(point_cmd(5'd17, 5'd9, 8'he0), m);
      push_exp(10'd305, 8'he0, n + 6);
      wait_idle(50, "t3");
      check("t3_overflow", 32'(overflow), 32'd0);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd0);

      // Overflow: 16-tile fill, then six points while it runs; the last two are dropped.
      send(fill_cmd(5'd0, 5'd6, 5'd7, 5'd7, 8'h11), n);
      k = 0;
      for (int y = 6; y <= 7; y++)
         for (int x = 0; x <= 7; x++) begin
            push_exp(10'(y * 32 + x), 8'h11, n + 2 + k);
            k++;
         end
      for (int i = 0; i < 6; i++) begin
         send(point_cmd(5'(20 + i), 5'd10, 8'(8'h40 + i)), m);
         if (i < 4) push_exp(10'(340 + i), 8'(8'h40 + i), n + 19 + 2 * i);
      end
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
      wait_idle(100, "t4");
      check("t4_drop_cnt_hold", 32'(drop_cnt), 32'd2);

      // Reversed and clamped fill: x 8..10, y 2..23, 66 writes.
      send(fill_cmd(5'd10, 5'd2, 5'd8, 5'd30, 8'h33), n);
      k = 0;
      for (int y = 2; y <= 23; y++)
         for (int x = 8; x <= 10; x++) begin
            push_exp(10'(y * 32 + x), 8'h33, n + 2 + k);
            k++;
         end
      wait_idle(200, "t5_fill");

      // Unknown op, out-of-range fill and point write nothing; the corner point still lands.
      send({4'h7, 28'h1234567}, n);
      send(fill_cmd(5'd0, 5'd24, 5'd5, 5'd30, 8'h44), n);
      send(point_cmd(5'd0, 5'd24, 8'h77), n);
      send(point_cmd(5'd31, 5'd23, 8'h5a), n);
      push_exp(10'd767, 8'h5a, n + 4);
      wait_idle(50, "t5_misc");

      // Reset in the middle of a full clear, with two points still queued.
      base = n_writes;
      send(fill_cmd(5'd0, 5'd0, 5'd31, 5'd23, 8'haa), n);
      for (int i = 0; i < 768; i++) push_exp(10'(i), 8'haa, n + 2 + i);
      send(point_cmd(5'd5, 5'd5, 8'h01), m);
      send(point_cmd(5'd6, 5'd6, 8'h02), m);
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_wr_en",     32'(wr_en),    32'd0);
      check("t6_busy",      32'(busy),     32'd0);
      check("t6_overflow",  32'(overflow), 32'd0);
      check("t6_drop_cnt",  32'(drop_cnt), 32'd0);
      check("t6_wr_addr",   32'(wr_addr),  32'd0);
      check("t6_wr_data",   32'(wr_data),  32'd0);
      check("t6_writes_before_rst", n_writes - base, 32'd50);
      exp_q.delete();
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("t6_fifo_flushed", 32'(busy), 32'd0);

      send(point_cmd(5'd2, 5'd0, 8'h99), n);
      push_exp(10'd2, 8'h99, n + 2);
      wait_idle(20, "t6_after");

      repeat (5) @(posedge clk);
      #1;
      check("final_pending", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/snake_tile_painter.md
Name: snake_tile_painter

Overview:
- Draw-command executor that sits directly downstream of the snake game core.
- Consumes the 32-bit {op, coords, color} command stream (cmd/cmd_vld) and buffers it in a small FIFO.
- Expands each command into single-tile writes to the 32x24 tile-color memory that the VGA pixel stage reads.
- Handles point draws (snake head, tail, prey) and rectangle fills (background clear).

Parameters:
- H_LOGIC_WIDTH, 5, tile column coordinate width
- V_LOGIC_WIDTH, 5, tile row coordinate width
- H_LOGIC_MAX, 5'd31, last valid column
- V_LOGIC_MAX, 5'd23, last valid row
- COLOR_ID_WIDTH, 8, color id width
- FIFO_DEPTH, 4, command FIFO entries (power of two)
- Derived localparams: CMD_WIDTH = 4 + 2*(H_LOGIC_WIDTH+V_LOGIC_WIDTH) + COLOR_ID_WIDTH (= 32); ADDR_WIDTH = V_LOGIC_WIDTH + H_LOGIC_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- cmd  in  CMD_WIDTH  draw command
- cmd_vld  in  1  command valid, sampled every cycle; no backpressure to the source
- wr_en  out  1  tile write strobe
- wr_addr  out  ADDR_WIDTH  tile address = {y, x}
- wr_data  out  COLOR_ID_WIDTH  tile color
- busy  out  1  high when the engine is not IDLE or the FIFO is non-empty
- overflow  out  1  sticky: a command was dropped
- drop_cnt  out  8  saturating count of dropped commands

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, overflow=0, drop_cnt=0; FIFO empty; FSM in IDLE.
- Reset mid-operation aborts the current fill and flushes the FIFO. wr_en is 0 from the first cycle after rst is sampled.
- Command decode, op = cmd[31:28]:
  - op 4'h0, POINT: x=[27:23], y=[22:18], color=[17:10]; bits [9:0] are ignored.
  - op 4'h1, FILL: x0=[27:23], y0=[22:18], x1=[17:13], y1=[12:8], color=[7:0].
  - Any other op is popped and discarded: no write, FSM stays in IDLE.
- FIFO push:
  - Push when cmd_vld=1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Otherwise the command is dropped: overflow <= 1 and drop_cnt increments, saturating at 255.
  - Duplicate commands are not filtered; each one is queued.
- FSM states: IDLE, POINT, FILL.
- IDLE:
  - If the FIFO is non-empty, pop one entry and register the decoded fields.
  - Next state is POINT (op 0), FILL (op 1) or IDLE (other ops).
  - A command pushed into an empty FIFO at edge N is popped at edge N+1. wr_en is first high in the cycle after edge N+2.
- POINT:
  - Drives one write cycle (wr_en=1, wr_addr={y,x}, wr_data=color), then returns to IDLE.
  - If x > H_LOGIC_MAX or y > V_LOGIC_MAX, no write is issued; the command is consumed in one cycle.
- FILL:
  - Bounds: xa=min(x0,x1), xb=min(max(x0,x1),H_LOGIC_MAX), ya=min(y0,y1), yb=min(max(y0,y1),V_LOGIC_MAX).
  - If xa > H_LOGIC_MAX or ya > V_LOGIC_MAX, no write is issued.
  - Otherwise, emit one write per cycle in row-major order: x from xa to xb, then y+1 and x back to xa. Total writes = (xb-xa+1)*(yb-ya+1).
  - The cycle after the write at (xb,yb), the FSM is in IDLE.
- Spacing: consecutive commands are separated by exactly one non-write IDLE cycle. The FIFO keeps accepting commands during POINT/FILL.
- wr_addr and wr_data are held at their last values when wr_en=0.

Optional Feature:
- Macro: SNAKE_PAINTER_WR_READY_EN.
- When defined:
  - Adds input port wr_rdy (1 bit), placed after cmd_vld.
  - A write completes only in a cycle where wr_en=1 and wr_rdy=1.
  - While wr_rdy=0, wr_en, wr_addr and wr_data hold and the fill position does not advance.
  - FIFO push is unaffected.
- When undefined: no wr_rdy port; every write completes in the cycle it is issued.

Test Plan:
1. Point: cmd={4'h0,x=3,y=5,8'h0f,10'b0} pulsed one cycle at edge N -> exactly one write at edge N+3 with wr_addr=163 and wr_data=8'h0f. busy falls after the write.
2. Full clear: {4'h1,0,0,31,23,8'hff} -> 768 consecutive writes, addr 0..767 ascending, data 8'hff; busy high throughout.
3. Burst: three points on three consecutive cycles (head 8'h0f, tail 8'hff, prey 8'he0) -> three writes in that order, one idle cycle between each; overflow stays 0.
4. Overflow: a fill is in progress, then 6 point commands arrive on consecutive cycles -> first 4 queued, last 2 dropped; overflow=1, drop_cnt=2; the 4 queued points are written after the fill.
5. Reversed/clamped fill: {4'h1,x0=10,y0=2,x1=8,y1=30,8'h33} -> x 8..10, y 2..23, 66 writes. Then op 4'h7 -> no write, FSM back in IDLE.
6. rst asserted mid full-clear -> wr_en=0 from the next cycle, no further writes, busy=0, FIFO empty; overflow and drop_cnt cleared.
